// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit multiplexed 7-segment driver:
// scan-state type, digit count and active-high segment patterns (bit 0 = a ... bit 6 = g).
package seg7_pkg;

    localparam int DIGITS = 2;

    typedef enum logic {
        ONES = 1'b0,
        TENS = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_PAT_0 = 7'h3F;  // abcdef
    localparam logic [6:0] SEG_PAT_1 = 7'h06;  // bc
    localparam logic [6:0] SEG_PAT_2 = 7'h5B;  // abdeg
    localparam logic [6:0] SEG_PAT_3 = 7'h4F;  // abcdg
    localparam logic [6:0] SEG_PAT_4 = 7'h66;  // bcfg
    localparam logic [6:0] SEG_PAT_5 = 7'h6D;  // acdfg
    localparam logic [6:0] SEG_PAT_6 = 7'h7D;  // acdefg
    localparam logic [6:0] SEG_PAT_7 = 7'h07;  // abc
    localparam logic [6:0] SEG_PAT_8 = 7'h7F;  // abcdefg
    localparam logic [6:0] SEG_PAT_9 = 7'h6F;  // abcdfg
    localparam logic [6:0] SEG_NONE  = 7'h00;

endpackage

// File: rtl/seg7_mux_driver_decode.sv
// Combinational decimal digit to active-high 7-segment pattern.
// Codes 10..15 never reach this block in normal use; they decode to all-off.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] pattern_o
);

    // Digit lookup
    always_comb begin
        pattern_o = SEG_NONE;
        case (digit_i)
            4'd0:    pattern_o = SEG_PAT_0;
            4'd1:    pattern_o = SEG_PAT_1;
            4'd2:    pattern_o = SEG_PAT_2;
            4'd3:    pattern_o = SEG_PAT_3;
            4'd4:    pattern_o = SEG_PAT_4;
            4'd5:    pattern_o = SEG_PAT_5;
            4'd6:    pattern_o = SEG_PAT_6;
            4'd7:    pattern_o = SEG_PAT_7;
            4'd8:    pattern_o = SEG_PAT_8;
            4'd9:    pattern_o = SEG_PAT_9;
            default: pattern_o = SEG_NONE;
        endcase
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// Two-digit time-multiplexed 7-segment driver for a 4-bit value (0..15).
// The value is sampled once per frame into a shadow register so one frame never
// mixes digits of two values. Each digit slot starts with a blank interval to
// suppress ghosting. All outputs are registered (one cycle latency).
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN -- when defined, a leading
// zero in the tens position keeps the tens anode dark for the whole slot.
//
// state | meaning
// ------+-------------------------------------------
// ONES  | ones-digit slot (anode an[0])
// TENS  | tens-digit slot (anode an[1]); its wrap loads the next frame's value
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] value,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

    // Physical "off" levels after polarity inversion
    localparam logic [6:0] SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_XOR  = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    logic [PW-1:0]       p_q, p_d;
    scan_state_t         state_q, state_d;
    logic [3:0]          sh_q, sh_d;
    logic [6:0]          seg_q, seg_d;
    logic [1:0]          an_q, an_d;
    logic                frame_tick_q, frame_tick_d;

    logic                p_wrap;
    logic                tens_digit;
    logic [3:0]          ones_digit;
    logic [3:0]          cur_digit;
    logic [6:0]          cur_pattern;
    logic                blank;
    logic [DIGITS-1:0]   an_on;

    // Prescaler and scan-state next state; the shadow loads on the TENS wrap
    always_comb begin
        p_wrap       = en && (p_q == P_LAST);
        p_d          = p_q;
        state_d      = state_q;
        sh_d         = sh_q;
        frame_tick_d = 1'b0;
        if (en) begin
            p_d = p_wrap ? '0 : p_q + 1'b1;
        end
        if (p_wrap) begin
            case (state_q)
                ONES: state_d = TENS;
                TENS: begin
                    state_d      = ONES;
                    sh_d         = value;
                    frame_tick_d = 1'b1;
                end
                default: state_d = ONES;
            endcase
        end
    end

    // Decimal split of the shadow value and digit selection for the current slot
    always_comb begin
        tens_digit = (sh_q >= 4'd10);
        ones_digit = tens_digit ? (sh_q - 4'd10) : sh_q;
        cur_digit  = (state_q == TENS) ? {3'b000, tens_digit} : ones_digit;
    end

    seg7_decode u_decode (
        .digit_i   (cur_digit),
        .pattern_o (cur_pattern)
    );

    // Blanking and anode select in active-high form, then physical polarity
    always_comb begin
        blank = !en || (p_q < P_BLANK);
        if (LZ_BLANK && (state_q == TENS) && !tens_digit) begin
            blank = 1'b1;
        end
        an_on = (state_q == ONES) ? 2'b01 : 2'b10;
        if (blank) begin
            an_d  = AN_XOR;
            seg_d = SEG_XOR;
        end else begin
            an_d  = an_on ^ AN_XOR;
            seg_d = cur_pattern ^ SEG_XOR;
        end
    end

    // Scan FSM with registered display outputs; async reset blanks immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q          <= '0;
            state_q      <= ONES;
            sh_q         <= 4'd0;
            seg_q        <= SEG_XOR;
            an_q         <= AN_XOR;
            frame_tick_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            state_q      <= state_d;
            sh_q         <= sh_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver with REFRESH_DIV=8, BLANK_CYCLES=2,
// active-low segments and anodes. The reference model tracks the number of
// enabled cycles since reset and derives slot/offset by plain arithmetic.
module tb_seg7_mux_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 2 * DIV;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] value;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;

    seg7_mux_driver #(
        .REFRESH_DIV    (DIV),
        .BLANK_CYCLES   (BLANK),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .value      (value),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Active-high pattern built from the segment letter list of a digit
    function automatic logic [6:0] pat(input int d);
        string s;
        logic [6:0] r;
        int idx;
        case (d)
            0: s = "abcdef";
            1: s = "bc";
            2: s = "abdeg";
            3: s = "abcdg";
            4: s = "bcfg";
            5: s = "acdfg";
            6: s = "acdefg";
            7: s = "abc";
            8: s = "abcdefg";
            default: s = "abcdfg";
        endcase
        r = 7'h00;
        for (int i = 0; i < s.len(); i++) begin
            idx = int'(s[i]) - 97;
            r[idx] = 1'b1;
        end
        return r;
    endfunction

    // Reference model: enabled-cycle count n_m gives frame position directly
    int unsigned n_m;
    logic [3:0]  sh_m;
    logic [6:0]  exp_seg;
    logic [1:0]  exp_an;
    logic        exp_ft;

    always @(posedge clk or negedge rst_n) begin : model
        int pos, off, dig;
        bit in_tens, dark;
        if (!rst_n) begin
            n_m     <= 0;
            sh_m    <= 4'd0;
            exp_seg <= 7'h7F;
            exp_an  <= 2'b11;
            exp_ft  <= 1'b0;
        end else begin
            pos     = int'(n_m % FRAME);
            in_tens = (pos >= DIV);
            off     = pos % DIV;
            dig     = in_tens ? int'(sh_m) / 10 : int'(sh_m) % 10;
            dark    = !en || (off < BLANK) || (LZB && in_tens && dig == 0);
            if (dark) begin
                exp_an  <= 2'b11;
                exp_seg <= 7'h7F;
            end else begin
                exp_an  <= in_tens ? 2'b01 : 2'b10;
                exp_seg <= ~pat(dig);
            end
            exp_ft <= en && (pos == FRAME - 1);
            if (en) begin
                if (pos == FRAME - 1) sh_m <= value;
                n_m <= n_m + 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int first_tick;
        rst_n = 1'b0; en = 1'b0; value = 4'd0;
        repeat (3) cyc();
        rst_n = 1'b1; en = 1'b1; value = 4'($urandom_range(0, 15));
        repeat (11) cyc();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 2'b11 || seg !== 7'h7F || frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: an=%b seg=%h ft=%b required an=11 seg=7f ft=0", an, seg, frame_tick);
        end
        cyc();
        rst_n = 1'b1; value = 4'd12;
        first_tick = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL reset_scan cyc%0d: an=%b seg=%h ft=%b required an=%b seg=%h ft=%b",
                         i, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
            if (i == 3) begin
                checks++;
                if (an !== 2'b10 || seg !== ~pat(0)) begin
                    failures++;
                    $display("FAIL reset_first_ones: an=%b seg=%h required an=10 seg=%h", an, seg, ~pat(0));
                end
            end
            if (frame_tick === 1'b1 && first_tick < 0) first_tick = i;
        end
        checks++;
        if (first_tick != FRAME) begin
            failures++;
            $display("FAIL reset_first_tick: at cycle %0d required %0d", first_tick, FRAME);
        end
    endtask

    task automatic test_value(input logic [3:0] v);
        bit got;
        int d_ones, d_tens;
        value = v; en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            cyc();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL value%0d_sync: an=%b seg=%h ft=%b required an=%b seg=%h ft=%b",
                         v, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
            if (frame_tick === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL value%0d_tick_timeout: no frame_tick, required one", v);
        end
        d_ones = int'(v) % 10;
        d_tens = int'(v) / 10;
        for (int k = 1; k <= FRAME; k++) begin
            cyc();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL value%0d_frame k%0d: an=%b seg=%h ft=%b required an=%b seg=%h ft=%b",
                         v, k, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
            checks++;
            if (an === 2'b00) begin
                failures++;
                $display("FAIL value%0d_both_anodes: an=%b required not 00", v, an);
            end
            if (k == 1 || k == 9) begin
                checks++;
                if (an !== 2'b11) begin
                    failures++;
                    $display("FAIL value%0d_blank k%0d: an=%b required 11", v, k, an);
                end
            end
            if (k == 5) begin
                checks++;
                if (an !== 2'b10 || seg !== ~pat(d_ones)) begin
                    failures++;
                    $display("FAIL value%0d_ones: an=%b seg=%h required an=10 seg=%h", v, an, seg, ~pat(d_ones));
                end
            end
            if (k == 13) begin
                checks++;
                if (LZB && d_tens == 0) begin
                    if (an !== 2'b11) begin
                        failures++;
                        $display("FAIL value%0d_tens_lz: an=%b required 11", v, an);
                    end
                end else if (an !== 2'b01 || seg !== ~pat(d_tens)) begin
                    failures++;
                    $display("FAIL value%0d_tens: an=%b seg=%h required an=01 seg=%h", v, an, seg, ~pat(d_tens));
                end
            end
        end
    endtask

    task automatic test_tearing();
        bit got;
        value = 4'd5; en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            cyc();
            if (frame_tick === 1'b1 && dut.sh_q == 4'd5) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL tearing_sync_timeout: no frame with value 5");
        end
        repeat (3) cyc();
        value = 4'd9;
        got = 1'b0;
        for (int k = 4; k <= FRAME + 6 && !got; k++) begin
            cyc();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL tearing k%0d: an=%b seg=%h ft=%b required an=%b seg=%h ft=%b",
                         k, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
            if (k == 7) begin
                checks++;
                if (seg !== ~pat(5)) begin
                    failures++;
                    $display("FAIL tearing_old_digit: seg=%h required %h", seg, ~pat(5));
                end
            end
            if (frame_tick === 1'b1) got = 1'b1;
        end
        repeat (4) cyc();
        checks++;
        if (an !== 2'b10 || seg !== ~pat(9)) begin
            failures++;
            $display("FAIL tearing_new_digit: an=%b seg=%h required an=10 seg=%h", an, seg, ~pat(9));
        end
    endtask

    task automatic test_enable_gap();
        bit got;
        int span;
        value = 4'd14; en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            cyc();
            if (frame_tick === 1'b1) got = 1'b1;
        end
        repeat (4) cyc();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (an !== 2'b11 || seg !== 7'h7F || frame_tick !== 1'b0 || an !== exp_an) begin
                failures++;
                $display("FAIL en_gap_blank k%0d: an=%b seg=%h ft=%b required an=11 seg=7f ft=0", k, an, seg, frame_tick);
            end
        end
        en = 1'b1;
        span = 9;
        got = 1'b0;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            cyc();
            span++;
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL en_gap_resume: an=%b seg=%h ft=%b required an=%b seg=%h ft=%b",
                         an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
            if (frame_tick === 1'b1) got = 1'b1;
        end
        checks++;
        if (span != FRAME + 5) begin
            failures++;
            $display("FAIL en_gap_period: tick spacing %0d required %0d", span, FRAME + 5);
        end
    endtask

    task automatic test_frame_period();
        int last, now;
        en = 1'b1;
        last = -1;
        now  = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            cyc();
            now++;
            if (frame_tick === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (now - last != FRAME) begin
                        failures++;
                        $display("FAIL frame_period: spacing %0d required %0d", now - last, FRAME);
                    end
                end
                last = now;
            end
        end
        checks++;
        if (last < 0) begin
            failures++;
            $display("FAIL frame_period_timeout: no frame_tick seen");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            value = 4'($urandom_range(0, 15));
            en    = ($urandom_range(0, 9) != 0);
            cyc();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL random cyc%0d: an=%b seg=%h ft=%b required an=%b seg=%h ft=%b",
                         i, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
            checks++;
            if (an === 2'b00) begin
                failures++;
                $display("FAIL random_both_anodes cyc%0d: an=%b required not 00", i, an);
            end
        end
    endtask

    initial begin
        test_reset();
        test_value(4'd13);
        test_value(4'd15);
        test_value(4'd10);
        test_value(4'd7);
        test_value(4'($urandom_range(0, 15)));
        test_tearing();
        test_enable_gap();
        test_frame_period();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
